mul_iter: RTL and testbench
===========================

Name: mul_iter

Overview:
- Multi-cycle shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
- Sits beside the ALU in the execute stage. Each iteration drives operands into an XLEN-bit ripple-carry adder and consumes its sum and carry-out.
- Uses a valid/ready handshake toward the issuing control logic, which stalls the pipeline while a result is pending.

Parameters:
- XLEN, 32, operand and result width in bits (must be >= 4).
- CNTW, 6, iteration counter width (must satisfy 2^CNTW > XLEN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request carries valid operands.
- in_ready  output  1  block can accept a request.
- op  input  2  00 MUL (low word), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- a  input  XLEN  multiplicand (rs1).
- b  input  XLEN  multiplier (rs2).
- out_valid  output  1  result is available.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  selected product word.

Behaviour:
- All state is registered. rst_n low asynchronously forces:
  - state=IDLE;
  - counter, accumulator, result = 0;
  - out_valid=0;
  - in_ready=1 (in_ready is decoded from state; it is 1 only in IDLE).
- States and transitions:
  - IDLE -> CALC on in_valid&&in_ready.
  - CALC -> NEG when counter reaches XLEN-1.
  - NEG -> DONE unconditionally.
  - DONE -> IDLE on out_ready.
- Accept (IDLE edge):
  - Latch op.
  - a is treated as signed for op 01/10. b is treated as signed for op 01 only.
  - Latch magnitudes |a| and |b| as unsigned XLEN values. 2^(XLEN-1) is representable, so the most-negative operand is handled.
  - Latch neg = sign(a) XOR sign(b), counting only the operands treated as signed.
  - acc_hi=0, acc_lo=|b|, counter=0.
- CALC (one iteration per cycle, exactly XLEN cycles):
  - Adder computes {c, s} = acc_hi + (acc_lo[0] ? |a| : 0), where c is the carry-out.
  - Then {acc_hi, acc_lo} <= {c, s, acc_lo} >> 1, i.e. a 2*XLEN+1-bit shift keeping the low 2*XLEN bits.
  - counter increments by 1.
- NEG (one cycle, always taken so latency is fixed):
  - If neg, the product P = {acc_hi, acc_lo} becomes (~P + 1) mod 2^(2*XLEN); otherwise P is unchanged.
  - result register is loaded with P[XLEN-1:0] for op 00, else P[2*XLEN-1:XLEN].
- DONE:
  - out_valid=1.
  - result and out_valid are held stable until out_ready is sampled high. That edge clears out_valid and returns to IDLE.
  - in_ready=0 throughout DONE, so no overlap with the next request.
- Latency: the accept edge is edge 0. out_valid is high after edge XLEN+1 (XLEN=32: visible in the cycle following the 33rd edge after accept). Minimum issue interval is XLEN+3 cycles.
- Ignored inputs:
  - in_valid in CALC/NEG/DONE has no effect.
  - Changes on a, b or op after the accept edge do not affect the result.
- out_ready asserted outside DONE is ignored.
- Reset asserted mid-operation:
  - The operation is discarded and no partial result appears.
  - The first cycle after rst_n deasserts shows in_ready=1 and out_valid=0.
- result keeps its last value in IDLE until the next NEG (not cleared); it is only meaningful while out_valid=1.

Test Plan:
- MUL a=7, b=6 with out_ready=1 -> result=0x0000002A. out_valid rises exactly XLEN+1 edges after accept, high for 1 cycle; in_ready=0 from accept until return to IDLE.
- a=b=0xFFFFFFFF, one request per op -> MUL 0x00000001, MULH 0x00000000, MULHSU 0xFFFFFFFF, MULHU 0xFFFFFFFE.
- a=b=0x80000000 -> MULH 0x40000000, MULHU 0x40000000, MUL 0x00000000. Also a=0x80000000, b=0x00000001 with MULH -> 0xFFFFFFFF.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result and out_valid stable, in_ready=0, new in_valid ignored. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 the next cycle.
- Operand churn: accept MULHU 3×5, then drive a, b and op randomly with in_valid=1 during CALC -> result=0x00000000 with no second accept. MUL 3×5 under the same churn -> 0x0000000F.
- Reset mid-CALC (rst_n low at the 10th CALC cycle, 2 cycles, asynchronous mid-cycle) -> out_valid=0 and in_ready=1 immediately. No spurious out_valid afterwards; a following MUL 0x12345678×0x10 -> 0x23456780.

Source files
------------

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group
// One XLEN-bit ripple-carry add per cycle on operand magnitudes; sign is applied once at the end.

module mul_iter_rca #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  logic [W:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar g = 0; g < W; g++) begin : g_fa
    assign o_sum[g]   = i_x[g] ^ i_y[g] ^ w_c[g];
    assign w_c[g + 1] = (i_x[g] & i_y[g]) | (w_c[g] & (i_x[g] ^ i_y[g]));
  end

  assign o_carry = w_c[W];

endmodule

module mul_iter #(
  parameter int XLEN = 32,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0]   L_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] L_ONE2   = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0]   L_CONE   = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0]   L_CLAST  = CNTW'(XLEN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_mag_a;
  logic [XLEN-1:0]   r_acc_hi;
  logic [XLEN-1:0]   r_acc_lo;
  logic [XLEN-1:0]   r_result;
  logic [CNTW-1:0]   r_cnt;
  logic              r_out_valid;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN-1:0]   w_addend;
  logic [XLEN-1:0]   w_sum;
  logic              w_carry;
  logic              w_last;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;

  // MULH treats both operands as signed, MULHSU only a; MUL/MULHU use raw bits
  assign w_a_neg = ((op == 2'b01) || (op == 2'b10)) && a[XLEN-1];
  assign w_b_neg = (op == 2'b01) && b[XLEN-1];
  assign w_mag_a = w_a_neg ? (~a + L_ONE) : a;
  assign w_mag_b = w_b_neg ? (~b + L_ONE) : b;

  assign w_addend = r_acc_lo[0] ? r_mag_a : '0;

  mul_iter_rca #(
    .W (XLEN)
  ) u_rca (
    .i_x     (r_acc_hi),
    .i_y     (w_addend),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_last     = (r_cnt == L_CLAST);
  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg ? (~w_prod + L_ONE2) : w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_NEG;
      S_NEG:   w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= 2'b00;
      r_neg       <= 1'b0;
      r_mag_a     <= '0;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op     <= op;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_mag_a  <= w_mag_a;
            r_acc_hi <= '0;
            r_acc_lo <= w_mag_b;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          // carry-out becomes the new MSB; multiplier bits retire out of acc_lo
          {r_acc_hi, r_acc_lo} <= {w_carry, w_sum, r_acc_lo[XLEN-1:1]};
          r_cnt                <= r_cnt + L_CONE;
        end
        S_NEG: begin
          {r_acc_hi, r_acc_lo} <= w_prod_fix;
          r_result    <= (r_op == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_mul_iter.sv
// tb/tb_mul_iter.sv - directed self-checking bench for mul_iter
// Expected products are hand-computed constants.

module tb_mul_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int total;
  int bad;

  mul_iter #(
    .XLEN (32),
    .CNTW (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp,
                        input bit churn, input int hold);
    int n;
    @(negedge clk);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    check({tag, " in_ready before accept"}, {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = churn;
    check({tag, " in_ready after accept"}, {31'b0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 200) begin
      if (churn) begin
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom);
      end
      @(negedge clk);
      n++;
      if (n == 20) check({tag, " in_ready mid calc"}, {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check({tag, " latency"}, n, 32'd33);
    check({tag, " result"}, result, exp);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        a        = $urandom;
        b        = $urandom;
        @(negedge clk);
        check({tag, " held out_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, " held result"}, result, exp);
        check({tag, " held in_ready"}, {31'b0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, " in_ready return"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int spurious;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;

    run_op("mul 7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b0, 0);
    run_op("mul ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    run_op("mulh ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 0);
    run_op("mulhsu ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    run_op("mulhu ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0);
    run_op("mulh min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 0);
    run_op("mulhu min", 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 0);
    run_op("mul min", 2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 0);
    run_op("mulh min x1", 2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 0);
    run_op("backpressure", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 5);
    run_op("churn mulhu", 2'b11, 32'd3, 32'd5, 32'h00000000, 1'b1, 0);
    run_op("churn mul", 2'b00, 32'd3, 32'd5, 32'h0000000F, 1'b1, 0);

    spurious = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid || !in_ready) spurious++;
    end
    check("no second accept", spurious, 32'd0);

    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 2'b00;
    a         = 32'hDEADBEEF;
    b         = 32'h00000003;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", {31'b0, out_valid}, 32'd0);
    check("async reset in_ready", {31'b0, in_ready}, 32'd1);
    check("async reset result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset in_ready", {31'b0, in_ready}, 32'd1);
    check("post reset out_valid", {31'b0, out_valid}, 32'd0);
    spurious = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("no spurious out_valid", spurious, 32'd0);

    run_op("mul after reset", 2'b00, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
